// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divider calculation used by both the RX and TX paths.
package uart_pkg;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] S_MID      = 4'd7;
  localparam logic [3:0] S_END      = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_rx_state_t;

  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick divider; tick is high for one clock every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver with framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  import uart_pkg::*;

  localparam int             DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int             N_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick;
  uart_rx_state_t       state;
  logic [3:0]           s_cnt;
  logic [N_W-1:0]       n_cnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clk   (clk_100MHz),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            s_cnt   <= '0;
            rx_busy <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches
        ST_START: begin
          if (tick) begin
            if (s_cnt == S_MID) begin
              if (!rx_s) begin
                state <= ST_DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                state   <= ST_IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (s_cnt == S_END) begin
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              s_cnt <= '0;
              if (n_cnt == N_LAST)
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              else
                n_cnt <= n_cnt + N_W'(1);
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (s_cnt == S_END) begin
              par_bit <= rx_s;
              s_cnt   <= '0;
              state   <= ST_STOP;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
`endif

        // Deciding at mid stop bit leaves half a bit to catch a back-to-back start edge
        ST_STOP: begin
          if (tick) begin
            if (s_cnt == S_END) begin
              s_cnt   <= '0;
              rx_busy <= 1'b0;
              if (rx_s) begin
                rx_data <= shreg;
                rx_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= (^shreg) ^ par_bit;
`endif
                state   <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_HIGH;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end

        // A held-low line (break) must return high before a new frame can start
        ST_WAIT_HIGH: begin
          if (rx_s)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
